// File: rtl/upsample.sv
`default_nettype none
// ============================================================================
// Module   : upsample
// Brief    : Nearest-neighbour 2x upsampler over valid/ready. Each input pixel
//            is replicated 2x2; a line buffer replays each row as the odd row.
//            Optional macro UPSAMPLE_LAST_EN adds the data_out_last port.
// Revision : 1.0 - initial release
// ============================================================================
module upsample #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_W       = 16,
    parameter int IN_H       = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  data_in_valid,
    input  logic [DATA_WIDTH-1:0] data_in_data,
    output logic                  data_in_ready,
    output logic                  data_out_valid,
    output logic [DATA_WIDTH-1:0] data_out_data,
    input  logic                  data_out_ready
`ifdef UPSAMPLE_LAST_EN
    ,
    output logic                  data_out_last
`endif
);

    localparam int c_XW = $clog2(2 * IN_W);
    localparam int c_YW = $clog2(2 * IN_H);
    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(2 * IN_W - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(2 * IN_H - 1);

    typedef enum logic [1:0] {
        PH_FILL_PASS = 2'd0,
        PH_FILL_REP  = 2'd1,
        PH_REPLAY    = 2'd2
    } phase_t;

    phase_t                w_phase;
    logic [c_XW-1:0]       r_x;
    logic [c_YW-1:0]       r_y;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_linebuf [IN_W];
    logic [c_XW-2:0]       w_col;
    logic                  w_out_fire;
    logic                  w_in_fire;

    assign w_col      = r_x[c_XW-1:1];
    assign w_out_fire = data_out_valid & data_out_ready;
    assign w_in_fire  = data_in_valid & data_in_ready;

    always_comb begin
        w_phase = PH_FILL_PASS;
        if (r_y[0]) begin
            w_phase = PH_REPLAY;
        end else if (r_x[0]) begin
            w_phase = PH_FILL_REP;
        end
    end

    // Purely combinational output path: the first copy leaves in the same cycle.
    always_comb begin
        data_out_valid = data_in_valid;
        data_out_data  = data_in_data;
        data_in_ready  = data_out_ready;
        unique case (w_phase)
            PH_FILL_REP: begin
                data_out_valid = 1'b1;
                data_out_data  = r_hold;
                data_in_ready  = 1'b0;
            end
            PH_REPLAY: begin
                data_out_valid = 1'b1;
                data_out_data  = r_linebuf[w_col];
                data_in_ready  = 1'b0;
            end
            default: begin
                data_out_valid = data_in_valid;
                data_out_data  = data_in_data;
                data_in_ready  = data_out_ready;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_out_fire) begin
            if (r_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hold <= '0;
        end else if (w_in_fire) begin
            r_hold <= data_in_data;
        end
    end

    // Line buffer carries no reset; every entry is written before it is replayed.
    always_ff @(posedge CLK) begin
        if (w_in_fire) begin
            r_linebuf[w_col] <= data_in_data;
        end
    end

`ifdef UPSAMPLE_LAST_EN
    assign data_out_last = data_out_valid & (r_x == c_X_LAST) & (r_y == c_Y_LAST);
`endif

endmodule
`default_nettype wire

// File: tb/tb_upsample.sv
`default_nettype none
// ============================================================================
// Module   : tb_upsample
// Brief    : Scoreboard bench for upsample: drivers push expected output
//            pixels into a queue, a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_upsample;

    localparam int DW = 16;
    localparam int IW = 16;
    localparam int IH = 16;
    localparam int OW = 2 * IW;
    localparam int OH = 2 * IH;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          data_in_valid = 1'b0;
    logic [DW-1:0] data_in_data = '0;
    logic          data_in_ready;
    logic          data_out_valid;
    logic [DW-1:0] data_out_data;
    logic          data_out_ready = 1'b1;
`ifdef UPSAMPLE_LAST_EN
    logic          data_out_last;
`endif

    upsample #(.DATA_WIDTH(DW), .IN_W(IW), .IN_H(IH)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .data_in_valid  (data_in_valid),
        .data_in_data   (data_in_data),
        .data_in_ready  (data_in_ready),
        .data_out_valid (data_out_valid),
        .data_out_data  (data_out_data),
        .data_out_ready (data_out_ready)
`ifdef UPSAMPLE_LAST_EN
        ,
        .data_out_last  (data_out_last)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          mx = 0;
    int          my = 0;
    bit          rnd_ready = 1'b0;
    bit          abort = 1'b0;
    bit          drv_done = 1'b0;
    bit          stall_v = 1'b0;
    logic [DW-1:0] stall_d = '0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c, input bit inv);
        logic [DW-1:0] v;
        v = DW'(r * IW + c);
        return inv ? ~v : v;
    endfunction

    // Expected output raster: out(x,y) = in(y>>1, x>>1).
    task automatic push_exp(input bit inv);
        for (int y = 0; y < OH; y++)
            for (int x = 0; x < OW; x++)
                exp_q.push_back(pix(y >> 1, x >> 1, inv));
    endtask

    task automatic push_pixel(input logic [DW-1:0] v, input bit gaps);
        int n;
        bit acc;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                data_in_valid = 1'b0;
                @(posedge CLK); #1;
            end
        end
        data_in_valid = 1'b1;
        data_in_data  = v;
        acc = 1'b0;
        n = 0;
        while (!acc && !abort && n < 2000) begin
            @(negedge CLK);
            acc = data_in_ready && !RESET;
            @(posedge CLK); #1;
            n++;
        end
        data_in_valid = 1'b0;
        if (!acc && !abort) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_accept_timeout: got not-accepted expected accepted (t=%0t)", $time);
        end
    endtask

    task automatic send_frame(input bit inv, input bit gaps);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                if (!abort) push_pixel(pix(r, c, inv), gaps);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge CLK);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_drv();
        int n = 0;
        while (!drv_done && n < 20000) begin
            @(posedge CLK);
            n++;
        end
        chk("driver_done", 32'(drv_done), 32'd1);
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
        #1 data_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: tracks output position from transfers, compares against the queue.
    always @(negedge CLK) begin
        if (RESET) begin
            mx = 0;
            my = 0;
            stall_v = 1'b0;
        end else begin
            if (stall_v) chk("stall_hold", 32'(data_out_data), 32'(stall_d));
            stall_v = 1'b0;
            if ((mx % 2) == 1 || (my % 2) == 1) begin
                chk("rep_valid", 32'(data_out_valid), 32'd1);
                if (data_in_valid) chk("in_ready_blocked", 32'(data_in_ready), 32'd0);
            end
            if (data_out_valid && data_out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %0h expected none (t=%0t)", data_out_data, $time);
                end else begin
                    chk("out_data", 32'(data_out_data), 32'(exp_q.pop_front()));
                end
`ifdef UPSAMPLE_LAST_EN
                chk("out_last", 32'(data_out_last), 32'((mx == OW - 1) && (my == OH - 1)));
`endif
                if (mx == OW - 1) begin
                    mx = 0;
                    my = (my == OH - 1) ? 0 : my + 1;
                end else begin
                    mx++;
                end
            end else if (data_out_valid && ((mx % 2) == 1 || (my % 2) == 1)) begin
                stall_v = 1'b1;
                stall_d = data_out_data;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, n;

        // Reset state: FILL_PASS passthrough.
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", 32'(data_out_valid), 32'd0);
        chk("rst_in_ready", 32'(data_in_ready), 32'd1);
        data_in_valid = 1'b1;
        data_in_data  = 16'hBEEF;
        #1;
        chk("rst_pass_valid", 32'(data_out_valid), 32'd1);
        chk("rst_pass_data", 32'(data_out_data), 32'h0000BEEF);
        data_in_valid = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Frame with ready always high; even rows block while valid is held.
        push_exp(1'b0);
        send_frame(1'b0, 1'b0);
        drain();

        // Random output backpressure and input gaps.
        rnd_ready = 1'b1;
        push_exp(1'b0);
        send_frame(1'b0, 1'b1);
        drain();
        rnd_ready = 1'b0;
        @(posedge CLK); #1;

        // Back-to-back frames: 2048 consecutive transfers, no bubble.
        push_exp(1'b0);
        push_exp(1'b1);
        drv_done = 1'b0;
        fork
            begin
                send_frame(1'b0, 1'b0);
                send_frame(1'b1, 1'b0);
                drv_done = 1'b1;
            end
        join_none
        n = 0;
        while (exp_q.size() == 2 * OW * OH && n < 1000) begin
            @(posedge CLK);
            n++;
        end
        t0 = cyc;
        drain();
        t1 = cyc;
        chk("no_bubble_span", 32'(t1 - t0), 32'(2 * OW * OH - 1));
        wait_drv();

        // Async reset at output (7,5), mid-REPLAY.
        push_exp(1'b0);
        drv_done = 1'b0;
        fork
            begin
                send_frame(1'b0, 1'b0);
                drv_done = 1'b1;
            end
        join_none
        n = 0;
        do begin
            @(posedge CLK); #2;
            n++;
        end while (!(mx == 7 && my == 5) && n < 5000);
        chk("reached_7_5", 32'(n < 5000), 32'd1);
        chk("pre_rst_replay", 32'(data_out_data), 32'(pix(2, 3, 1'b0)));
        RESET = 1'b1;
        #1;
        chk("arst_valid", 32'(data_out_valid), 32'(data_in_valid));
        chk("arst_ready", 32'(data_in_ready), 32'(data_out_ready));
        chk("arst_pass_data", 32'(data_out_data), 32'(pix(3, 0, 1'b0)));
        abort = 1'b1;
        wait_drv();
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        abort = 1'b0;
        push_exp(1'b0);
        send_frame(1'b0, 1'b0);
        drain();

        repeat (5) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
